// File: rtl/ifetch_bridge.sv
// ifetch_bridge: instruction fetch engine between the IF stage and a
// 64-bit instruction memory bus. Issues one doubleword-aligned read at a
// time, selects the 32-bit word addressed by pc[2], holds it until the IF
// stage consumes it, and discards data made stale by a redirect.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   pc                current fetch pc from the IF stage
//   jump_en           redirect; pc holds the jump target from the next cycle
//   hazard_stop       IF stage cannot accept an instruction this cycle
//   instr/instr_valid fetched instruction, held until consumed or redirected
//   ifetch_en         instruction consumed; IF stage advances pc
//   req_valid/ready   memory read request handshake, address on req_addr
//   rsp_valid/data    single-cycle in-order read response
//   fetch_err         sticky error: bus timeout or misaligned pc
module ifetch_bridge #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] pc,
    input  logic        jump_en,
    input  logic        hazard_stop,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        ifetch_en,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [63:0] req_addr,
    input  logic        rsp_valid,
    input  logic [63:0] rsp_data,
    output logic        fetch_err
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DROP,
        ERR
    } state_t;

    state_t            state;
    logic [63:2]       fetch_pc;
    logic              lock;
    logic              drop_pend;
    logic [CNT_W-1:0]  cnt;

    logic [63:2]       sel_pc;
    logic              misalign;
    logic              accept;
    logic              timeout;

    // Once a request is stalled the address is frozen, so jumps cannot
    // withdraw or alter it; only an unlocked pc is checked for alignment.
    assign sel_pc      = lock ? fetch_pc : pc[63:2];
    assign misalign    = !lock && (pc[1:0] != 2'b00);
    assign req_valid   = (state == REQ) && !misalign;
    assign req_addr    = (state == REQ) ? {sel_pc[63:3], 3'b000} : 64'h0;
    assign instr_valid = (state == HOLD);
    assign ifetch_en   = (state == HOLD) && !hazard_stop && !jump_en;
    assign fetch_err   = (state == ERR);
    assign accept      = req_valid && req_ready;
    assign timeout     = (cnt == CNT_LAST);

    // Fetch sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            instr     <= 32'h0;
            fetch_pc  <= 62'h0;
            lock      <= 1'b0;
            drop_pend <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: state <= REQ;

                REQ: begin
                    fetch_pc <= sel_pc;
                    if (misalign) begin
                        state <= ERR;
                    end else if (!accept) begin
                        lock <= 1'b1;
                        if (jump_en) drop_pend <= 1'b1;
                    end else begin
                        lock      <= 1'b0;
                        drop_pend <= 1'b0;
                        cnt       <= '0;
                        // A redirect seen while the request was pending makes
                        // its data stale; it still has to be drained.
                        state     <= (drop_pend || jump_en) ? DROP : WAIT;
                    end
                end

                WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (rsp_valid) begin
                        if (!jump_en) begin
                            instr <= fetch_pc[2] ? rsp_data[63:32] : rsp_data[31:0];
                            state <= HOLD;
                        end else begin
                            state <= REQ;
                        end
                    end else if (jump_en) begin
                        cnt   <= '0;
                        state <= DROP;
                    end else if (timeout) begin
                        state <= ERR;
                    end
                end

                HOLD: begin
                    if (jump_en || !hazard_stop) state <= REQ;
                end

                // Further redirects are ignored here: pc already tracks the
                // latest target and is sampled on return to REQ.
                DROP: begin
                    cnt <= cnt + CNT_W'(1);
                    if (rsp_valid)    state <= REQ;
                    else if (timeout) state <= ERR;
                end

                ERR: state <= ERR;

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_bridge.sv
// tb_ifetch_bridge: directed stimulus for ifetch_bridge with a scoreboard.
// Stimulus pushes expected request addresses and consumed instructions into
// queues; a negedge monitor pops and compares on every handshake/consume.
module tb_ifetch_bridge;

    localparam int unsigned TIMEOUT = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc;
    logic        jump_en;
    logic        hazard_stop;
    logic [31:0] instr;
    logic        instr_valid;
    logic        ifetch_en;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        rsp_valid;
    logic [63:0] rsp_data;
    logic        fetch_err;

    int n_cmp = 0;
    int n_mis = 0;

    logic [63:0] exp_addr_q[$];
    logic [31:0] exp_instr_q[$];

    always #5 clk = ~clk;

    ifetch_bridge #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .jump_en    (jump_en),
        .hazard_stop(hazard_stop),
        .instr      (instr),
        .instr_valid(instr_valid),
        .ifetch_en  (ifetch_en),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .fetch_err  (fetch_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && req_valid && req_ready) begin
            if (exp_addr_q.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL req_unexpected: got addr 0x%0h, expected no request (t=%0t)", req_addr, $time);
            end else begin
                chk("req_addr", req_addr, exp_addr_q.pop_front());
            end
        end
        if (!rst && instr_valid && ifetch_en) begin
            if (exp_instr_q.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL instr_unexpected: got instr 0x%0h, expected no consume (t=%0t)", instr, $time);
            end else begin
                chk("instr", 64'(instr), 64'(exp_instr_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [63:0] p);
        rst         = 1'b1;
        pc          = p;
        jump_en     = 1'b0;
        hazard_stop = 1'b0;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_data    = 64'h0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Waits (bounded) until the DUT is in a REQ cycle; returns at that negedge.
    task automatic wait_req(input logic post_hold);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (i == 0 && post_hold) begin
                chk("post_hold_valid", 64'(instr_valid), 64'(0));
                chk("post_hold_ifetch_en", 64'(ifetch_en), 64'(0));
            end
            if (req_valid) seen = 1'b1;
            else tick();
        end
        if (!seen) begin
            n_cmp++;
            n_mis++;
            $display("FAIL req_wait: got no req_valid in 20 cycles, expected a request");
        end
    endtask

    // One complete fetch: response k cycles after accept, h hazard cycles in HOLD.
    task automatic fetch(input logic [63:0] p, input logic [63:0] d, input int k,
                         input int h, input logic post_hold, input logic [63:0] exp_a,
                         input logic [31:0] exp_w);
        pc        = p;
        req_ready = 1'b1;
        exp_addr_q.push_back(exp_a);
        exp_instr_q.push_back(exp_w);
        wait_req(post_hold);
        tick();
        req_ready = 1'b0;
        repeat (k - 1) tick();
        rsp_valid   = 1'b1;
        rsp_data    = d;
        hazard_stop = (h > 0);
        @(negedge clk);
        chk("rsp_cycle_valid", 64'(instr_valid), 64'(0));
        tick();
        rsp_valid = 1'b0;
        rsp_data  = 64'h0;
        for (int i = 0; i <= h; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(instr_valid), 64'(1));
            chk("hold_instr", 64'(instr), 64'(exp_w));
            chk("hold_ifetch_en", 64'(ifetch_en), 64'(i == h));
            tick();
            if (i + 1 == h) hazard_stop = 1'b0;
        end
    endtask

    initial begin
        // Reset state
        do_reset(64'h8000_0000);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_instr", 64'(instr), 64'h0);
        chk("rst_instr_valid", 64'(instr_valid), 64'(0));
        chk("rst_req_valid", 64'(req_valid), 64'(0));
        chk("rst_ifetch_en", 64'(ifetch_en), 64'(0));
        chk("rst_fetch_err", 64'(fetch_err), 64'(0));
        chk("rst_req_addr", req_addr, 64'h0);
        tick();
        rst = 1'b0;

        // Tests 1-3: lower word, upper word, hazard hold, slower responses
        fetch(64'h8000_0000, 64'h0000_0013_0010_0093, 1, 0, 1'b0, 64'h8000_0000, 32'h0010_0093);
        fetch(64'h8000_0004, 64'h0000_0013_0010_0093, 1, 0, 1'b1, 64'h8000_0000, 32'h0000_0013);
        fetch(64'h8000_0008, 64'hDEAD_BEEF_1234_5678, 2, 3, 1'b1, 64'h8000_0008, 32'h1234_5678);
        fetch(64'h8000_000C, 64'hDEAD_BEEF_1234_5678, 3, 0, 1'b1, 64'h8000_0008, 32'hDEAD_BEEF);

        // Test 4: redirect while waiting, late response discarded
        do_reset(64'h8000_0008);
        req_ready = 1'b1;
        exp_addr_q.push_back(64'h8000_0008);
        wait_req(1'b0);
        tick();
        req_ready = 1'b0;
        jump_en   = 1'b1;
        @(negedge clk);
        chk("t4_wait_valid", 64'(instr_valid), 64'(0));
        tick();
        jump_en = 1'b0;
        pc      = 64'h8000_0100;
        @(negedge clk);
        chk("t4_drop_req_valid", 64'(req_valid), 64'(0));
        tick();
        rsp_valid = 1'b1;
        rsp_data  = 64'hBADB_ADBA_DBAD_BADB;
        @(negedge clk);
        chk("t4_drop_valid", 64'(instr_valid), 64'(0));
        tick();
        rsp_valid = 1'b0;
        fetch(64'h8000_0100, 64'h1111_2222_3333_4444, 1, 0, 1'b1, 64'h8000_0100, 32'h3333_4444);

        // Test 5: stalled request with redirect, address frozen, then drained
        do_reset(64'h8000_0010);
        wait_req(1'b0);
        chk("t5_addr_c1", req_addr, 64'h8000_0010);
        tick();
        jump_en = 1'b1;
        @(negedge clk);
        chk("t5_addr_c2", req_addr, 64'h8000_0010);
        tick();
        jump_en = 1'b0;
        pc      = 64'h8000_0200;
        @(negedge clk);
        chk("t5_addr_c3", req_addr, 64'h8000_0010);
        tick();
        @(negedge clk);
        chk("t5_addr_c4", req_addr, 64'h8000_0010);
        tick();
        req_ready = 1'b1;
        exp_addr_q.push_back(64'h8000_0010);
        tick();
        req_ready = 1'b0;
        @(negedge clk);
        chk("t5_drop_req_valid", 64'(req_valid), 64'(0));
        tick();
        rsp_valid = 1'b1;
        rsp_data  = 64'h0BAD_0BAD_0BAD_0BAD;
        @(negedge clk);
        chk("t5_drop_valid", 64'(instr_valid), 64'(0));
        tick();
        rsp_valid = 1'b0;
        fetch(64'h8000_0200, 64'h5555_6666_7777_8888, 1, 0, 1'b1, 64'h8000_0200, 32'h7777_8888);

        // Test 6: bus timeout, sticky error, late response ignored, reset recovers
        do_reset(64'h8000_0020);
        req_ready = 1'b1;
        exp_addr_q.push_back(64'h8000_0020);
        wait_req(1'b0);
        tick();
        req_ready = 1'b0;
        repeat (TIMEOUT - 1) tick();
        @(negedge clk);
        chk("t6_err_before", 64'(fetch_err), 64'(0));
        tick();
        @(negedge clk);
        chk("t6_err_set", 64'(fetch_err), 64'(1));
        chk("t6_err_req_valid", 64'(req_valid), 64'(0));
        rsp_valid = 1'b1;
        rsp_data  = 64'h1234_1234_1234_1234;
        tick();
        rsp_valid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("t6_err_sticky", 64'(fetch_err), 64'(1));
        chk("t6_err_instr_valid", 64'(instr_valid), 64'(0));
        do_reset(64'h8000_0040);
        @(negedge clk);
        chk("t6_err_cleared", 64'(fetch_err), 64'(0));
        fetch(64'h8000_0040, 64'h0000_0000_00A0_0513, 1, 0, 1'b0, 64'h8000_0040, 32'h00A0_0513);

        // Test 7: response on the last cycle before timeout still completes
        fetch(64'h8000_0044, 64'hCAFE_F00D_0000_0001, TIMEOUT, 0, 1'b1, 64'h8000_0040, 32'hCAFE_F00D);
        @(negedge clk);
        chk("t7_no_err", 64'(fetch_err), 64'(0));

        // Test 8: misaligned pc raises error without issuing a request
        do_reset(64'h8000_0002);
        req_ready = 1'b1;
        @(negedge clk);
        chk("t8_idle_req_valid", 64'(req_valid), 64'(0));
        tick();
        @(negedge clk);
        chk("t8_req_forced_low", 64'(req_valid), 64'(0));
        tick();
        @(negedge clk);
        chk("t8_err", 64'(fetch_err), 64'(1));
        req_ready = 1'b0;
        tick();

        chk("addr_q_drained", 64'(exp_addr_q.size()), 64'(0));
        chk("instr_q_drained", 64'(exp_instr_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
